// File: rtl/wb_master_sequencer.sv
// wb_master_sequencer: Wishbone classic single-word read/write/poll initiator for the accelerator slave port.
// Latency: accept->stb 1 cycle, ack sampled->rsp_valid 1 cycle, rsp handshake->cmd_ready 1 cycle.
// Backpressure: one command outstanding; cmd_ready low until the response is consumed; rsp held while rsp_ready low.
module wb_master_sequencer #(
  parameter int TIMEOUT  = 64,
  parameter int POLL_GAP = 8,
  parameter int POLL_MAX = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RESP} state_e;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_TMO   = 2'd1;
  localparam logic [1:0] E_POLL  = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  // Last-cycle compare values: counters start at 0 on entry to their state.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);
  localparam logic [31:0] POLL_LIM = 32'(POLL_MAX);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        bus_q, bus_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] rdat_q, rdat_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] poll_q, poll_d;
  logic [31:0] poll_inc;

  // Saturating increment of the poll read count.
  assign poll_inc = (poll_q == '1) ? poll_q : poll_q + 32'd1;

  // Next-state and registered-output logic for the command/bus sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bus_d   = bus_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    tgt_d   = tgt_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          addr_d = cmd_addr_i;
          tgt_d  = cmd_data_i;
          poll_d = '0;
          tmo_d  = '0;
          rdat_d = '0;
          if (cmd_op_i == 2'b11) begin
            err_d   = E_ILL;
            state_d = S_RESP;
          end else begin
            bus_d   = 1'b1;
            we_d    = (cmd_op_i == OP_WR);
            wdat_d  = (cmd_op_i == OP_WR) ? cmd_data_i : '0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          // Ack beats a coinciding timeout; strobe always drops for a cycle after ack.
          bus_d = 1'b0;
          we_d  = 1'b0;
          tmo_d = '0;
          err_d = E_OK;
          if (op_q == OP_WR) begin
            rdat_d  = '0;
            state_d = S_RESP;
          end else if (op_q == OP_RD) begin
            rdat_d  = wb_data_i;
            state_d = S_RESP;
          end else begin
            rdat_d = wb_data_i;
            poll_d = poll_inc;
            if (wb_data_i == tgt_q) begin
              state_d = S_RESP;
            end else if (poll_inc >= POLL_LIM) begin
              err_d   = E_POLL;
              state_d = S_RESP;
            end else begin
              gap_d   = '0;
              state_d = S_GAP;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          bus_d   = 1'b0;
          we_d    = 1'b0;
          tmo_d   = '0;
          rdat_d  = '0;
          err_d   = E_TMO;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          bus_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_BUS;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops the bus and discards any pending work.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
      bus_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      tgt_q   <= '0;
      rdat_q  <= '0;
      err_q   <= E_OK;
      tmo_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bus_q   <= bus_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      tgt_q   <= tgt_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready_o = (state_q == S_IDLE) && wb_rst_ni;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rdat_q;
  assign rsp_err_o   = err_q;
  assign wb_cyc_o    = bus_q;
  assign wb_stb_o    = bus_q;
  assign wb_we_o     = we_q;
  assign wbs_sel_o   = {4{bus_q}};
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdat_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_master_sequencer.sv
// tb_wb_master_sequencer: directed scoreboard bench for the Wishbone sequencer.
// Latency: n/a (bench).
// Backpressure: drives rsp_ready low in one test to stall the response.
module tb_wb_master_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        busy_o;

  wb_master_sequencer #(.TIMEOUT(16), .POLL_GAP(8), .POLL_MAX(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i   (cmd_op_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wbs_sel_o  (wbs_sel_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] sb_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rd_default = 32'h0;
  int          ack_delay = 1;
  int          stb_cnt = 0;

  int          runs[$];
  int          gaps[$];
  int          cur_run = 0;
  int          gap_run = 0;
  int          bus_bad = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] exp_wdat = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", nm, act, exp);
    end
  endfunction

  // Slave: acks on the ack_delay-th cycle of a strobe; ack_delay 0 never acks.
  initial begin
    wb_ack_i  = 1'b0;
    wb_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_stb_o && !wb_ack_i) begin
        stb_cnt++;
        if (ack_delay != 0 && stb_cnt == ack_delay) begin
          wb_ack_i = 1'b1;
          if (rd_q.size() > 0) wb_data_i = rd_q.pop_front();
          else wb_data_i = rd_default;
        end
      end else begin
        wb_ack_i = 1'b0;
        stb_cnt  = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got data=0x%08h err=%0d want no response", rsp_data_o, rsp_err_o);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", rsp_data_o, e[31:0]);
          chk("rsp_err", {30'b0, rsp_err_o}, {30'b0, e[33:32]});
        end
      end
    end
  end

  // Bus monitor: strobe run lengths, idle gaps between strobes, and signal sanity.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc_o) begin
        if (cur_run == 0 && runs.size() > 0) gaps.push_back(gap_run);
        cur_run++;
        gap_run = 0;
        if (wb_stb_o !== 1'b1 || wbs_sel_o !== 4'hF || wb_we_o !== exp_we ||
            wb_addr_o !== exp_addr || (exp_we && wb_data_o !== exp_wdat)) bus_bad++;
      end else begin
        if (cur_run > 0) begin
          runs.push_back(cur_run);
          cur_run = 0;
        end
        gap_run++;
        if (wb_stb_o !== 1'b0 || wbs_sel_o !== 4'h0 || wb_we_o !== 1'b0) bus_bad++;
      end
    end
  end

  task automatic clr(input logic we, input logic [31:0] a, input logic [31:0] wd);
    runs.delete();
    gaps.delete();
    cur_run  = 0;
    gap_run  = 0;
    bus_bad  = 0;
    exp_we   = we;
    exp_addr = a;
    exp_wdat = wd;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    cmd_op_i    = op;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept got no cmd_ready within 200 cycles want ready");
    end
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy_o && !wb_cyc_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_done got pending=%0d busy=%0b want idle within 3000 cycles", nm, sb_q.size(), busy_o);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_addr_i  = 32'h0;
    cmd_data_i  = 32'h0;
    rsp_ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'b0, cmd_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o, wbs_sel_o, busy_o, 4'b0},
        32'h0);
    chk("reset_rsp_data", rsp_data_o, 32'h0);
    chk("reset_bus_addr_data", wb_addr_o | wb_data_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, cmd_ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Write, slave acks on the third strobe cycle
    clr(1'b1, 32'h3000_0000, 32'h1);
    ack_delay = 3;
    sb_q.push_back({2'd0, 32'h0});
    send(2'b01, 32'h3000_0000, 32'h1);
    chk("wr_accept_to_stb", {30'b0, wb_stb_o, wb_we_o}, 32'd3);
    wait_done("wr");
    chk("wr_nstb", runs.size(), 1);
    chk("wr_stb_len", runs[0], 3);
    chk("wr_bus_sig", bus_bad, 0);

    // Read returning DEADBEEF
    clr(1'b0, 32'h3000_0008, 32'h0);
    ack_delay = 1;
    rd_q.push_back(32'hDEAD_BEEF);
    sb_q.push_back({2'd0, 32'hDEAD_BEEF});
    send(2'b00, 32'h3000_0008, 32'h0);
    wait_done("rd");
    chk("rd_nstb", runs.size(), 1);
    chk("rd_bus_sig", bus_bad, 0);

    // Poll until status clears: three reads separated by 8 idle cycles
    clr(1'b0, 32'h3000_0004, 32'h0);
    ack_delay = 2;
    rd_q.push_back(32'hFFFF_FFFF);
    rd_q.push_back(32'hFFFF_FFFF);
    rd_q.push_back(32'h0);
    sb_q.push_back({2'd0, 32'h0});
    send(2'b10, 32'h3000_0004, 32'h0);
    wait_done("poll");
    chk("poll_nstb", runs.size(), 3);
    chk("poll_ngaps", gaps.size(), 2);
    chk("poll_gap0", gaps[0], 8);
    chk("poll_gap1", gaps[1], 8);
    chk("poll_bus_sig", bus_bad, 0);

    // Timeout: slave never acks
    clr(1'b0, 32'h3000_0000, 32'h0);
    ack_delay = 0;
    sb_q.push_back({2'd1, 32'h0});
    send(2'b00, 32'h3000_0000, 32'h0);
    wait_done("tmo");
    chk("tmo_nstb", runs.size(), 1);
    chk("tmo_stb_len", runs[0], 16);
    chk("tmo_bus_sig", bus_bad, 0);

    // Poll exhausted: value never matches, four reads then err 2 with last value
    clr(1'b0, 32'h3000_0004, 32'h0);
    ack_delay  = 1;
    rd_default = 32'h5;
    sb_q.push_back({2'd2, 32'h5});
    send(2'b10, 32'h3000_0004, 32'h0);
    wait_done("pmax");
    chk("pmax_nstb", runs.size(), 4);
    chk("pmax_bus_sig", bus_bad, 0);
    rd_default = 32'h0;

    // Reserved op: immediate err 3, no bus cycle
    clr(1'b0, 32'h0, 32'h0);
    sb_q.push_back({2'd3, 32'h0});
    send(2'b11, 32'h3000_0000, 32'h1234_5678);
    chk("ill_rsp_valid_next", {31'b0, rsp_valid_o}, 32'd1);
    wait_done("ill");
    chk("ill_nstb", runs.size(), 0);

    // Response stall: rsp held and cmd_ready low for 10 cycles
    clr(1'b0, 32'h3000_000C, 32'h0);
    rsp_ready_i = 1'b0;
    rd_q.push_back(32'h1234_5678);
    sb_q.push_back({2'd0, 32'h1234_5678});
    send(2'b00, 32'h3000_000C, 32'h0);
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        bad = 0;
        break;
      end
    end
    chk("stall_rsp_seen", bad, 0);
    repeat (10) begin
      @(negedge clk);
      if (rsp_data_o !== 32'h1234_5678 || rsp_err_o !== 2'd0 || cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) bad++;
    end
    chk("stall_hold", bad, 0);
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b1;
    wait_done("stall");
    chk("stall_ready_after", {31'b0, cmd_ready_o}, 32'd1);

    // Reset pulse during BUS, then a normal read
    clr(1'b0, 32'h3000_0010, 32'h0);
    ack_delay = 0;
    send(2'b00, 32'h3000_0010, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst_mid_outputs", {16'b0, cmd_ready_o, rsp_valid_o, rsp_err_o, wb_we_o, wbs_sel_o, busy_o, 6'b0} |
        rsp_data_o | wb_addr_o | wb_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clr(1'b0, 32'h3000_0014, 32'h0);
    ack_delay = 2;
    rd_q.push_back(32'hCAFE_F00D);
    sb_q.push_back({2'd0, 32'hCAFE_F00D});
    send(2'b00, 32'h3000_0014, 32'h0);
    wait_done("post_rst");
    chk("post_rst_nstb", runs.size(), 1);
    chk("post_rst_bus_sig", bus_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
